micro_decode_stage: RTL
=======================

Name: micro_decode_stage

Overview:
- Pipelined, parametrised successor to the combinational microinstruction field splitter.
- Registers the decoded microinstruction fields and the data address behind a valid/ready handshake with a 2-entry skid buffer.
- Supports pipeline flush, and optionally a read-after-write hazard stall.
- Sits between the microcode ROM fetch stage and the datapath execute stage.

Parameters:
- ALU_W, 4, ALU opcode field width.
- SH_W, 2, shifter control width.
- M_W, 2, memory control width.
- B_W, 6, B-bus source select width.
- C_W, 6, C-bus source select width.
- T_W, 7, T field width.
- A_W, 5, A (destination) field width.
- ADDR_W, 11, data address width.
- HAZ_GAP, 2, cycles a written A register stays hazardous (only with the optional feature).
- INSTR_W (localparam), ALU_W+SH_W+1+M_W+B_W+C_W+T_W+A_W (=33), microinstruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  micro_instr_ROM / data_address_in valid.
- in_ready  out  1  stage can accept an entry.
- micro_instr_ROM  in  INSTR_W  raw microinstruction.
- data_address_in  in  ADDR_W  data address accompanying the instruction.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  execute stage accepts the entry.
- ALU2, SH2, KMx2, M2, B2, C2, T2, A2  out  ALU_W, SH_W, 1, M_W, B_W, C_W, T_W, A_W  decoded fields.
- data_address_out  out  ADDR_W  registered data address.
- hazard_stall  out  1  head entry held by hazard (constant 0 without the feature).

Behaviour:
- Field split of micro_instr_ROM, MSB first:
  - ALU occupies [INSTR_W-1 -: ALU_W].
  - Then SH, then KMx (1 bit), then M, B, C, T.
  - A occupies [A_W-1:0].
  - Default widths give ALU[32:29], SH[28:27], KMx[26], M[25:24], B[23:18], C[17:12], T[11:5], A[4:0].
- Storage: head entry and skid entry, each holding the decoded fields, the address and a valid bit. All outputs are driven from head registers only; nothing combinational from input to output.
- in_ready = !skid_valid && !flush.
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Latency: an entry accepted into an empty stage appears on the outputs the next cycle, so out_valid=1 one cycle after accept.
- Ordering: strictly FIFO.
  - Accept with head empty, or with head popping and skid empty: the entry goes to head.
  - Accept while head is occupied and not popping: the entry goes to skid.
  - Pop with skid valid: skid moves to head, and skid may be refilled the same cycle only if it was freed (in_ready is computed from the registered skid_valid, so no refill that cycle).
- Full (skid valid): in_ready=0. Input is held by upstream, never dropped.
- Empty: out_valid=0 and field outputs hold their last values. The execute stage must qualify with out_valid.
- flush: at the next edge head_valid and skid_valid clear and the hazard counter clears. Any in_valid in the flush cycle is dropped (in_ready=0). A pop in the flush cycle still completes.
- Reset (asynchronous, any time including mid-transfer):
  - all valids, field outputs, data_address_out, the hazard counter and hazard_stall go to 0;
  - in_ready becomes 1 after reset deasserts.
- out_valid and its fields are stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: MICRO_DECODE_HAZARD_EN.
- With the macro defined:
  - On each pop with A2!=0, the stage records last_A=A2 and loads haz_cnt=HAZ_GAP.
  - haz_cnt decrements each cycle down to 0.
  - While haz_cnt!=0 and the head entry has B2==last_A or C2==last_A, out_valid is forced to 0 and hazard_stall=1. The head entry is retained.
  - A new pop reloads the counter.
  - flush and reset clear haz_cnt.
- Without the macro: no hazard logic, and hazard_stall is tied to 0.

Test Plan:
- Reset mid-transfer: assert reset with both entries valid -> out_valid=0, all fields 0, in_ready=1 after release.
- Decode check: push ALU=A, SH=1, KMx=1, M=2, B=15h, C=2Ah, T=55h, A=1Fh, addr=7FFh with out_ready=1 -> next cycle out_valid=1 and each output equals its field.
- Backpressure: out_ready=0, push I0, I1, then I2 offered -> in_ready=0 after I1, I2 held. Raise out_ready -> I0, I1, I2 emerge in order on consecutive pops, none lost or duplicated.
- Flush: two entries buffered, flush=1 with in_valid=1 (I3) -> next cycle out_valid=0, I3 not accepted; then I4 passes with latency 1.
- Hazard (macro on, HAZ_GAP=2): pop an instruction with A=5, next instruction has B=5 -> hazard_stall=1 and out_valid=0 for 2 cycles, then it issues. With C=5 the same result. With B=C=6 there is no stall.
- Macro off: same hazard stimulus -> back-to-back issue, hazard_stall=0.

Source files
------------

// File: rtl/micro_decode_stage.sv
// rtl/micro_decode_stage.sv - registered microinstruction field decoder behind a 2-entry skid buffer
// Optional read-after-write hazard stall is enabled by defining MICRO_DECODE_HAZARD_EN.
module micro_decode_stage #(
  parameter int ALU_W   = 4,
  parameter int SH_W    = 2,
  parameter int M_W     = 2,
  parameter int B_W     = 6,
  parameter int C_W     = 6,
  parameter int T_W     = 7,
  parameter int A_W     = 5,
  parameter int ADDR_W  = 11,
  parameter int HAZ_GAP = 2,
  localparam int INSTR_W = ALU_W + SH_W + 1 + M_W + B_W + C_W + T_W + A_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] micro_instr_ROM,
  input  logic [ADDR_W-1:0]  data_address_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALU_W-1:0]   ALU2,
  output logic [SH_W-1:0]    SH2,
  output logic               KMx2,
  output logic [M_W-1:0]     M2,
  output logic [B_W-1:0]     B2,
  output logic [C_W-1:0]     C2,
  output logic [T_W-1:0]     T2,
  output logic [A_W-1:0]     A2,
  output logic [ADDR_W-1:0]  data_address_out,
  output logic               hazard_stall
);

  localparam int T_LSB  = A_W;
  localparam int C_LSB  = T_LSB + T_W;
  localparam int B_LSB  = C_LSB + C_W;
  localparam int M_LSB  = B_LSB + B_W;
  localparam int K_LSB  = M_LSB + M_W;
  localparam int SH_LSB = K_LSB + 1;

  logic [INSTR_W-1:0] head_instr, skid_instr;
  logic [ADDR_W-1:0]  head_addr, skid_addr;
  logic               head_valid, skid_valid;
  logic               stall, accept, pop;

  // in_ready looks only at the registered skid state, so a freed skid cannot refill in the same cycle
  assign in_ready  = !skid_valid && !flush;
  assign out_valid = head_valid && !stall;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_instr <= '0;
      head_addr  <= '0;
      head_valid <= 1'b0;
      skid_instr <= '0;
      skid_addr  <= '0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        head_instr <= skid_instr;
        head_addr  <= skid_addr;
        skid_valid <= 1'b0;
      end else if (accept) begin
        head_instr <= micro_instr_ROM;
        head_addr  <= data_address_in;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (accept) begin
      if (head_valid) begin
        skid_instr <= micro_instr_ROM;
        skid_addr  <= data_address_in;
        skid_valid <= 1'b1;
      end else begin
        head_instr <= micro_instr_ROM;
        head_addr  <= data_address_in;
        head_valid <= 1'b1;
      end
    end
  end

  assign ALU2             = head_instr[INSTR_W-1 -: ALU_W];
  assign SH2              = head_instr[SH_LSB +: SH_W];
  assign KMx2             = head_instr[K_LSB];
  assign M2               = head_instr[M_LSB +: M_W];
  assign B2               = head_instr[B_LSB +: B_W];
  assign C2               = head_instr[C_LSB +: C_W];
  assign T2               = head_instr[T_LSB +: T_W];
  assign A2               = head_instr[A_W-1:0];
  assign data_address_out = head_addr;

`ifdef MICRO_DECODE_HAZARD_EN
  localparam int HCW = $clog2(HAZ_GAP + 1);

  logic [A_W-1:0] last_a;
  logic [HCW-1:0] haz_cnt;

  // Head is held while it reads a register written by a recently issued entry
  assign stall = head_valid && (haz_cnt != '0) &&
                 ((B2 == B_W'(last_a)) || (C2 == C_W'(last_a)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      haz_cnt <= '0;
      last_a  <= '0;
    end else if (flush) begin
      haz_cnt <= '0;
    end else if (pop && (A2 != '0)) begin
      haz_cnt <= HCW'(HAZ_GAP);
      last_a  <= A2;
    end else if (haz_cnt != '0) begin
      haz_cnt <= haz_cnt - 1'b1;
    end
  end
`else
  assign stall = 1'b0;
`endif

  assign hazard_stall = stall;

endmodule
